// File: rtl/pm_capture_pkg.sv
// rtl/pm_capture_pkg.sv - shared types and constants for the phasemeter capture stage
package pm_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam int MIN_DEC          = 2;
    localparam int AXIS_TDATA_WIDTH = 32;
    localparam int ENTRY_WIDTH      = 2 * AXIS_TDATA_WIDTH + 1;

    function automatic int entry_width(input int data_width);
        return 2 * data_width + 1;
    endfunction

endpackage

// File: rtl/pm_capture_axis_if.sv
// rtl/pm_capture_axis_if.sv - framed output stream with tvalid/tready/tlast handshake
interface pm_capture_axis_if #(
    parameter int AXIS_TDATA_WIDTH = 32
);
    logic [AXIS_TDATA_WIDTH-1:0] tdata;
    logic                        tvalid;
    logic                        tready;
    logic                        tlast;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/pm_capture_fifo.sv
// rtl/pm_capture_fifo.sv - single-clock FIFO with registered read data
module pm_capture_fifo
    import pm_capture_pkg::*;
#(
    parameter int WIDTH = ENTRY_WIDTH,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
endmodule

// File: rtl/pm_capture_axis.sv
// rtl/pm_capture_axis.sv - decimating {PE, PI} capture with framed two-beat stream readout
module pm_capture_axis
    import pm_capture_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int DEC_WIDTH        = 16,
    parameter int DEC              = 4064,
    parameter int VAR_DEC          = 0,
    parameter int FIFO_DEPTH       = 1024,
    parameter int FRAME_LEN        = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PE_tdata,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PI_tdata,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PARAM_tdata,
    pm_capture_axis_if.master           M_AXIS,
    output logic                        busy,
    output logic                        overflow
);
    localparam int W     = AXIS_TDATA_WIDTH;
    localparam int EW    = entry_width(AXIS_TDATA_WIDTH);
    localparam int DEC_C = (DEC < MIN_DEC) ? MIN_DEC : DEC;
    localparam int FW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int OW    = $clog2(FIFO_DEPTH) + 1;

    state_t               state, state_nx;
    logic [DEC_WIDTH-1:0] ratio, dec_cnt, param_dec;
    logic [FW-1:0]        fcnt, fcnt_nx;
    logic [OW-1:0]        occ;
    logic                 tick, wr, frame_end, full_occ;
    logic [EW-1:0]        rd_data, ent;
    logic                 fifo_full, fifo_empty, rd_en;
    logic                 pend, ent_v, ph, ent_done, load;
    logic                 unused_param;

    assign param_dec    = S_AXIS_PARAM_tdata[DEC_WIDTH-1:0];
    assign unused_param = ^S_AXIS_PARAM_tdata;

    assign tick      = (state != ST_IDLE) && (dec_cnt == ratio - DEC_WIDTH'(1));
    assign frame_end = (fcnt == FW'(FRAME_LEN - 1));
    // Occupancy counts every pair not yet fully sent, including the two staging registers
    assign full_occ  = (occ == OW'(FIFO_DEPTH));
    assign wr        = tick && !full_occ && !fifo_full;
    assign fcnt_nx   = wr ? (frame_end ? '0 : fcnt + FW'(1)) : fcnt;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (en) state_nx = ST_RUN;
            ST_RUN:    if (!en) state_nx = (fcnt_nx == '0) ? ST_IDLE : ST_FINISH;
            ST_FINISH: if (wr && frame_end) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            dec_cnt  <= '0;
            fcnt     <= '0;
            ratio    <= DEC_WIDTH'(DEC_C);
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE) begin
                dec_cnt <= '0;
                fcnt    <= '0;
                if (en && VAR_DEC != 0) begin
                    ratio <= (param_dec < DEC_WIDTH'(MIN_DEC)) ? DEC_WIDTH'(MIN_DEC) : param_dec;
                end
            end else begin
                dec_cnt <= tick ? '0 : dec_cnt + DEC_WIDTH'(1);
                fcnt    <= fcnt_nx;
            end
            if (tick && !wr) begin
                overflow <= 1'b1;
            end
        end
    end

    pm_capture_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr),
        .wr_data ({frame_end, S_AXIS_PE_tdata, S_AXIS_PI_tdata}),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // pend marks rd_data as holding a popped entry waiting for the output slot
    assign ent_done = ent_v && ph && M_AXIS.tready;
    assign load     = pend && (!ent_v || ent_done);
    assign rd_en    = !fifo_empty && (!pend || load);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend  <= 1'b0;
            ent_v <= 1'b0;
            ph    <= 1'b0;
            ent   <= '0;
            occ   <= '0;
        end else begin
            if (rd_en) begin
                pend <= 1'b1;
            end else if (load) begin
                pend <= 1'b0;
            end
            if (load) begin
                ent   <= rd_data;
                ent_v <= 1'b1;
                ph    <= 1'b0;
            end else if (ent_done) begin
                ent_v <= 1'b0;
                ph    <= 1'b0;
            end else if (ent_v && M_AXIS.tready) begin
                ph <= 1'b1;
            end
            occ <= occ + OW'(wr) - OW'(ent_done);
        end
    end

    assign M_AXIS.tdata  = ph ? ent[W-1:0] : ent[2*W-1:W];
    assign M_AXIS.tvalid = ent_v;
    assign M_AXIS.tlast  = ent_v && ph && ent[EW-1];
endmodule

// File: tb/tb_pm_capture_axis.sv
// tb/tb_pm_capture_axis.sv - randomized and directed bench with a transaction-level capture model
module tb_pm_capture_axis;
    localparam int W     = 32;
    localparam int DEC   = 4;
    localparam int FL    = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        sel = 1'b0;
    logic        tready = 1'b0;
    logic [31:0] cyc = '0;
    logic [31:0] param = '0;
    logic [31:0] pe, pi;
    int          tests = 0, fails = 0, xfers = 0;
    int          tr_mode = 0, tr_idx = 0;
    logic        tr_val = 1'b0;
    bit          chk_on = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;
    assign pe = cyc;
    assign pi = ~cyc;

    pm_capture_axis_if #(.AXIS_TDATA_WIDTH(W)) m0 ();
    pm_capture_axis_if #(.AXIS_TDATA_WIDTH(W)) m1 ();
    assign m0.tready = tready;
    assign m1.tready = tready;

    logic en0, en1, busy0, busy1, ovf0, ovf1;
    assign en0 = en & ~sel;
    assign en1 = en & sel;

    pm_capture_axis #(.AXIS_TDATA_WIDTH(W), .DEC_WIDTH(16), .DEC(DEC), .VAR_DEC(0),
                      .FIFO_DEPTH(DEPTH), .FRAME_LEN(FL)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .S_AXIS_PE_tdata(pe), .S_AXIS_PI_tdata(pi),
        .S_AXIS_PARAM_tdata(param), .M_AXIS(m0), .busy(busy0), .overflow(ovf0));

    pm_capture_axis #(.AXIS_TDATA_WIDTH(W), .DEC_WIDTH(16), .DEC(DEC), .VAR_DEC(1),
                      .FIFO_DEPTH(DEPTH), .FRAME_LEN(FL)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .S_AXIS_PE_tdata(pe), .S_AXIS_PI_tdata(pi),
        .S_AXIS_PARAM_tdata(param), .M_AXIS(m1), .busy(busy1), .overflow(ovf1));

    logic        tv_s, tl_s, busy_s, ovf_s;
    logic [31:0] td_s;
    assign tv_s   = sel ? m1.tvalid : m0.tvalid;
    assign tl_s   = sel ? m1.tlast  : m0.tlast;
    assign td_s   = sel ? m1.tdata  : m0.tdata;
    assign busy_s = sel ? busy1 : busy0;
    assign ovf_s  = sel ? ovf1  : ovf0;

    always @(posedge clk) begin
        #1;
        case (tr_mode)
            1:       begin tready = (tr_idx % 4 == 0) || (tr_idx % 4 == 3); tr_idx++; end
            2:       tready = 1'($urandom_range(0, 1));
            default: tready = tr_val;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beats {data, last}; a pair stays counted until its second beat leaves
    logic [32:0] q[$];
    logic [32:0] e;
    bit          m_active = 0, m_fin = 0, m_ovf = 0, wrote, prev_stall = 0, last_tl = 0;
    int          written = 0, m_ratio = DEC, occ;
    logic [31:0] m_entry = '0, c, prev_td;
    logic        prev_tl;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", busy_s, m_active);
            chk("overflow", ovf_s, m_ovf);
            if (prev_stall) begin
                chk("stall_tvalid", tv_s, 1);
                chk("stall_tdata", td_s, prev_td);
                chk("stall_tlast", tl_s, prev_tl);
            end
        end
        if (rst) begin
            q.delete();
            m_active = 0; m_fin = 0; m_ovf = 0; written = 0; prev_stall = 0;
        end else if (chk_on) begin
            occ = (q.size() + 1) / 2;
            if (tv_s && tready) begin
                xfers++;
                chk("beat_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("beat_tdata", td_s, e[32:1]);
                    chk("beat_tlast", tl_s, e[0]);
                end
                last_tl = tl_s;
            end
            prev_stall = tv_s && !tready;
            prev_td    = td_s;
            prev_tl    = tl_s;
            c = cyc;
            if (!m_active) begin
                if (en) begin
                    m_active = 1; m_fin = 0; m_entry = c; written = 0;
                    m_ratio = sel ? ((param[15:0] < 2) ? 2 : int'(param[15:0])) : DEC;
                end
            end else begin
                wrote = 0;
                if (int'(c - m_entry) % m_ratio == 0) begin
                    if (occ < DEPTH) begin
                        q.push_back({c, 1'b0});
                        q.push_back({~c, 1'(written % FL == FL - 1)});
                        written++;
                        wrote = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (!m_fin) begin
                    if (!en) begin
                        if (written % FL == 0) m_active = 0;
                        else m_fin = 1;
                    end
                end else if (wrote && written % FL == 0) begin
                    m_active = 0; m_fin = 0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (k < budget && (busy_s || tv_s || q.size() != 0)) begin step(1); k++; end
        chk("drain_done", k < budget, 1);
    endtask

    initial begin
        int n, base;
        step(3);
        rst = 1'b0;
        chk_on = 1'b1;
        chk("rst_tvalid", m0.tvalid, 0);
        chk("rst_tlast", m0.tlast, 0);
        chk("rst_tdata", m0.tdata, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_overflow", ovf0, 0);
        chk("rst_tvalid_var", m1.tvalid, 0);

        tr_val = 1'b1;
        step(1);
        en = 1'b1;
        n = 0;
        while (!m0.tvalid && n < 50) begin step(1); n++; end
        chk("first_tvalid_latency", n, 7);
        step(40);
        en = 1'b0;
        drain(100);

        tr_mode = 1;
        en = 1'b1;
        step(48);
        en = 1'b0;
        drain(200);
        tr_mode = 0;

        tr_val = 1'b0;
        step(1);
        en = 1'b1;
        step(60);
        chk("ovf_set", ovf0, 1);
        en = 1'b0;
        step(2);
        chk("ovf_idle", busy0, 0);
        base = xfers;
        tr_val = 1'b1;
        step(60);
        chk("ovf_beats", xfers - base, 16);
        chk("ovf_sticky", ovf0, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("ovf_cleared", ovf0, 0);

        en = 1'b1;
        n = 0;
        while (written < 2 && n < 100) begin step(1); n++; end
        en = 1'b0;
        n = 0;
        while (busy0 && n < 100) begin step(1); n++; end
        chk("finish_pairs", written, 4);
        drain(100);
        chk("finish_tlast", last_tl, 1);
        base = xfers;
        step(30);
        chk("post_finish_beats", xfers - base, 0);

        tr_val = 1'b0;
        step(1);
        en = 1'b1;
        n = 0;
        while (q.size() < 6 && n < 100) begin step(1); n++; end
        chk("queued_three", q.size(), 6);
        rst = 1'b1;
        en = 1'b0;
        step(1);
        chk("mid_rst_tvalid", m0.tvalid, 0);
        chk("mid_rst_tlast", m0.tlast, 0);
        chk("mid_rst_overflow", ovf0, 0);
        chk("mid_rst_busy", busy0, 0);
        rst = 1'b0;
        tr_val = 1'b1;
        base = xfers;
        step(30);
        chk("post_rst_beats", xfers - base, 0);

        sel = 1'b1;
        param = 32'd7;
        step(1);
        en = 1'b1;
        step(60);
        en = 1'b0;
        drain(100);
        param = 32'd0;
        step(1);
        en = 1'b1;
        step(40);
        en = 1'b0;
        drain(100);

        sel = 1'b0;
        step(1);
        tr_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            step(1);
        end
        en = 1'b0;
        drain(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
